// File: rtl/wb_arbiter_pkg.sv
// Shared Wishbone bus constants, target decode and arbiter state encoding.
// Imported by the arbiter, its round-robin picker, the bus interface and sim helpers.
package wb_arbiter_pkg;

  localparam int WB_ADDR_WIDTH = 20;
  localparam int DATA_WIDTH    = 8;

  // Region tags on addr[19:17]; the VRAM/VROM windows live inside the RAM region.
  localparam logic [2:0] WB_RAM_BASE = 3'b000;
  localparam logic [2:0] WB_REG_BASE = 3'b010;
  localparam logic [2:0] WB_KBD_BASE = 3'b011;

  typedef enum logic [1:0] {
    WB_TGT_RAM,
    WB_TGT_REG,
    WB_TGT_KBD,
    WB_TGT_NONE
  } wb_target_t;

  typedef enum logic {
    ST_IDLE,
    ST_GRANT
  } wb_state_t;

  function automatic wb_target_t wb_decode(input logic [2:0] region);
    case (region)
      WB_RAM_BASE: return WB_TGT_RAM;
      WB_REG_BASE: return WB_TGT_REG;
      WB_KBD_BASE: return WB_TGT_KBD;
      default:     return WB_TGT_NONE;
    endcase
  endfunction

endpackage

// File: rtl/wb_arbiter_if.sv
// Requester-side and slave-side signal bundle of the Wishbone arbiter.
// The arbiter uses the slave modport; the surrounding requesters/slaves use master.
interface wb_arbiter_if #(
  parameter int NUM_MASTERS = 2
);
  import wb_arbiter_pkg::*;

  logic [NUM_MASTERS-1:0]               m_cyc_i;
  logic [NUM_MASTERS-1:0]               m_stb_i;
  logic [NUM_MASTERS-1:0]               m_we_i;
  logic [NUM_MASTERS*WB_ADDR_WIDTH-1:0] m_addr_i;
  logic [NUM_MASTERS*DATA_WIDTH-1:0]    m_dout_i;
  logic [DATA_WIDTH-1:0]                m_din_o;
  logic [NUM_MASTERS-1:0]               m_ack_o;
  logic [NUM_MASTERS-1:0]               m_stall_o;
  logic [NUM_MASTERS-1:0]               m_err_o;
  logic [NUM_MASTERS-1:0]               grant_o;
  logic                                 s_cyc_o;
  logic                                 s_stb_o;
  logic                                 s_we_o;
  logic [WB_ADDR_WIDTH-1:0]             s_addr_o;
  logic [DATA_WIDTH-1:0]                s_dout_o;
  logic [DATA_WIDTH-1:0]                s_din_i;
  logic                                 s_ack_i;
  logic                                 s_stall_i;
  logic                                 ram_sel_o;
  logic                                 reg_sel_o;
  logic                                 kbd_sel_o;

  modport slave (
    input  m_cyc_i, m_stb_i, m_we_i, m_addr_i, m_dout_i,
    input  s_din_i, s_ack_i, s_stall_i,
    output m_din_o, m_ack_o, m_stall_o, m_err_o, grant_o,
    output s_cyc_o, s_stb_o, s_we_o, s_addr_o, s_dout_o,
    output ram_sel_o, reg_sel_o, kbd_sel_o
  );

  modport master (
    output m_cyc_i, m_stb_i, m_we_i, m_addr_i, m_dout_i,
    output s_din_i, s_ack_i, s_stall_i,
    input  m_din_o, m_ack_o, m_stall_o, m_err_o, grant_o,
    input  s_cyc_o, s_stb_o, s_we_o, s_addr_o, s_dout_o,
    input  ram_sel_o, reg_sel_o, kbd_sel_o
  );

endinterface

// File: rtl/wb_arbiter_rr_picker.sv
// Combinational round-robin picker: first requester after `last`, wrapping,
// returned as a one-hot vector (all-zero when nobody requests).
module wb_arbiter_rr_picker #(
  parameter int N  = 2,
  parameter int LW = 1
) (
  input  logic [N-1:0]  req,
  input  logic [LW-1:0] last,
  output logic [N-1:0]  pick
);

  always_comb begin
    int   idx;
    logic found;
    pick  = '0;
    found = 1'b0;
    idx   = 0;
    for (int i = 1; i <= N; i++) begin
      idx = (int'(last) + i) % N;
      if (!found && req[idx]) begin
        pick[idx] = 1'b1;
        found     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// Round-robin Wishbone arbiter with RAM/REG/KBD address decode; unmapped strobes end in err.
// Optional stalled-strobe watchdog enabled by defining WB_TIMEOUT_EN.
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int NUM_MASTERS = 2
`ifdef WB_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 64
`endif
) (
  input  logic        wb_clock_i,
  input  logic        wb_reset_ni,
  wb_arbiter_if.slave bus,
  output wb_state_t   state_o
);

  localparam int N  = NUM_MASTERS;
  localparam int LW = $clog2(NUM_MASTERS);
  localparam int AW = WB_ADDR_WIDTH;
  localparam int DW = DATA_WIDTH;

  wb_state_t       state;
  logic [N-1:0]    grant, pick, err_q;
  logic [LW-1:0]   last, gidx;
  logic            cyc_k, stb_k, we_k;
  logic [AW-1:0]   addr_k;
  logic [DW-1:0]   dout_k;
  wb_target_t      tgt;
  logic            active, mapped, k_stall, tmo_block, tmo_fire;

  wb_arbiter_rr_picker #(.N(N), .LW(LW)) u_picker (
    .req  (bus.m_cyc_i),
    .last (last),
    .pick (pick)
  );

  always_comb begin
    cyc_k  = 1'b0;
    stb_k  = 1'b0;
    we_k   = 1'b0;
    addr_k = '0;
    dout_k = '0;
    gidx   = '0;
    for (int i = 0; i < N; i++) begin
      if (grant[i]) begin
        cyc_k  = bus.m_cyc_i[i];
        stb_k  = bus.m_stb_i[i];
        we_k   = bus.m_we_i[i];
        addr_k = bus.m_addr_i[i*AW +: AW];
        dout_k = bus.m_dout_i[i*DW +: DW];
        gidx   = LW'(i);
      end
    end
  end

  assign active  = (state == ST_GRANT);
  assign tgt     = wb_decode(addr_k[AW-1 -: 3]);
  assign mapped  = (tgt != WB_TGT_NONE);
  // Pipelined handshake: a strobe transfers on the edge where stb=1 and stall=0;
  // unmapped strobes are accepted locally (stall=0) and answered with err next cycle.
  assign k_stall = mapped ? bus.s_stall_i : 1'b0;

  assign bus.s_cyc_o   = active & cyc_k & ~tmo_block;
  assign bus.s_stb_o   = bus.s_cyc_o & stb_k & mapped;
  assign bus.s_we_o    = we_k;
  assign bus.s_addr_o  = addr_k;
  assign bus.s_dout_o  = dout_k;
  assign bus.ram_sel_o = bus.s_cyc_o & (tgt == WB_TGT_RAM);
  assign bus.reg_sel_o = bus.s_cyc_o & (tgt == WB_TGT_REG);
  assign bus.kbd_sel_o = bus.s_cyc_o & (tgt == WB_TGT_KBD);

  assign bus.m_din_o   = active ? bus.s_din_i : '0;
  assign bus.m_ack_o   = grant & {N{bus.s_cyc_o & mapped & bus.s_ack_i}};
  assign bus.m_stall_o = ~grant | (grant & {N{k_stall | tmo_block}});
  assign bus.m_err_o   = err_q;
  assign bus.grant_o   = grant;
  assign state_o       = state;

`ifdef WB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] tmo_cnt;
  logic          pend, accept, acked, outstanding;

  assign accept      = bus.s_cyc_o & stb_k & ~k_stall;
  assign acked       = bus.s_cyc_o & mapped & bus.s_ack_i;
  assign outstanding = stb_k | pend;
  assign tmo_fire    = bus.s_cyc_o & ~accept & ~acked & outstanding &
                       (tmo_cnt == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge wb_clock_i or negedge wb_reset_ni) begin
    if (!wb_reset_ni) begin
      tmo_cnt   <= '0;
      pend      <= 1'b0;
      tmo_block <= 1'b0;
    end else if (!active || !cyc_k) begin
      tmo_cnt   <= '0;
      pend      <= 1'b0;
      tmo_block <= 1'b0;
    end else begin
      if (accept || acked) tmo_cnt <= '0;
      else if (outstanding && !tmo_block) tmo_cnt <= tmo_cnt + 1'b1;
      if (accept && mapped) pend <= 1'b1;
      else if (acked) pend <= 1'b0;
      if (tmo_fire) tmo_block <= 1'b1;
    end
  end
`else
  assign tmo_block = 1'b0;
  assign tmo_fire  = 1'b0;
`endif

  always_ff @(posedge wb_clock_i or negedge wb_reset_ni) begin
    if (!wb_reset_ni) begin
      state <= ST_IDLE;
      grant <= '0;
      last  <= LW'(N - 1);
      err_q <= '0;
    end else begin
      err_q <= '0;
      case (state)
        ST_IDLE: begin
          if (|bus.m_cyc_i) begin
            grant <= pick;
            state <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          // Dropping cyc always passes through IDLE, giving one turnaround cycle.
          if (!cyc_k) begin
            state <= ST_IDLE;
            grant <= '0;
            last  <= gidx;
          end else if ((stb_k && !mapped && !tmo_block) || tmo_fire) begin
            err_q <= grant;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: reset, RAM read, round-robin, REG/KBD writes,
// unmapped err, abandoned cycle, async reset mid-grant, and the WB_TIMEOUT_EN watchdog.
`timescale 1ns/1ps
module tb_wb_arbiter;
  import wb_arbiter_pkg::*;

  localparam int NM = 2;

  logic      clk = 1'b0;
  logic      rst_n = 1'b0;
  wb_state_t state;
  int        total = 0;
  int        bad = 0;

  logic [31:0]   exp_q[$];  // slave-side transfers {ram,reg,kbd, we, addr, dout}
  logic [31:0]   ack_q[$];  // master-side acks {ack mask, din}
  logic [NM-1:0] gq[$];
  logic [NM-1:0] g;

  wb_arbiter_if #(.NUM_MASTERS(NM)) bus ();

  always #5 clk = ~clk;

  wb_arbiter #(
    .NUM_MASTERS(NM)
`ifdef WB_TIMEOUT_EN
    , .TIMEOUT_CYCLES(8)
`endif
  ) dut (
    .wb_clock_i  (clk),
    .wb_reset_ni (rst_n),
    .bus         (bus),
    .state_o     (state)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic drv(input int k, input logic cyc, input logic stb, input logic we,
                     input logic [19:0] a, input logic [7:0] d);
    bus.m_cyc_i[k]          = cyc;
    bus.m_stb_i[k]          = stb;
    bus.m_we_i[k]           = we;
    bus.m_addr_i[k*20 +: 20] = a;
    bus.m_dout_i[k*8 +: 8]   = d;
  endtask

  function automatic logic [31:0] xf(input logic [2:0] sel, input logic we,
                                     input logic [19:0] a, input logic [7:0] d);
    return {sel, we, a, d};
  endfunction

  function automatic logic [31:0] ak(input logic [NM-1:0] mask, input logic [7:0] d);
    return {{(24-NM){1'b0}}, mask, d};
  endfunction

  task automatic bus_idle();
    bus.m_cyc_i   = '0;
    bus.m_stb_i   = '0;
    bus.m_we_i    = '0;
    bus.m_addr_i  = '0;
    bus.m_dout_i  = '0;
    bus.s_din_i   = '0;
    bus.s_ack_i   = 1'b0;
    bus.s_stall_i = 1'b0;
  endtask

  task automatic do_reset();
    bus_idle();
    rst_n = 1'b0;
    tick();
    tick();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Slave-side scoreboard: every accepted strobe must match the next expected transfer.
  always @(negedge clk) begin
    if (rst_n && bus.s_stb_o && !bus.s_stall_i) begin
      if (exp_q.size() == 0)
        chk("xfer_unexpected", xf({bus.ram_sel_o, bus.reg_sel_o, bus.kbd_sel_o},
            bus.s_we_o, bus.s_addr_o, bus.s_dout_o), 32'hFFFF_FFFF);
      else
        chk("xfer", xf({bus.ram_sel_o, bus.reg_sel_o, bus.kbd_sel_o},
            bus.s_we_o, bus.s_addr_o, bus.s_dout_o), exp_q.pop_front());
    end
  end

  // Master-side scoreboard: every ack must match the next expected ack/read data.
  always @(negedge clk) begin
    if (rst_n && |bus.m_ack_o) begin
      if (ack_q.size() == 0)
        chk("ack_unexpected", ak(bus.m_ack_o, bus.m_din_o), 32'hFFFF_FFFF);
      else
        chk("ack", ak(bus.m_ack_o, bus.m_din_o), ack_q.pop_front());
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values
    bus_idle();
    #2;
    chk("rst_grant", bus.grant_o, 0);
    chk("rst_scyc", bus.s_cyc_o, 0);
    chk("rst_stall", bus.m_stall_o, 2'b11);
    chk("rst_ack_err", {bus.m_ack_o, bus.m_err_o}, 0);
    chk("rst_state", state, ST_IDLE);
    do_reset();

    // M0 RAM read, two stall cycles then ack with 0xA5
    tick();
    drv(0, 1, 1, 0, 20'h08000, 8'h00);
    bus.s_stall_i = 1'b1;
    exp_q.push_back(xf(3'b100, 1'b0, 20'h08000, 8'h00));
    mid();
    chk("rd_latency_scyc", bus.s_cyc_o, 0);
    chk("rd_latency_grant", bus.grant_o, 0);
    tick(); mid();
    chk("rd_grant", bus.grant_o, 2'b01);
    chk("rd_ctrl", {bus.s_cyc_o, bus.s_stb_o, bus.ram_sel_o, bus.reg_sel_o, bus.kbd_sel_o}, 5'b11100);
    chk("rd_stall1", bus.m_stall_o, 2'b11);
    tick(); mid();
    chk("rd_stall2", bus.m_stall_o, 2'b11);
    tick();
    bus.s_stall_i = 1'b0;
    mid();
    chk("rd_accept_stall", bus.m_stall_o, 2'b10);
    tick();
    bus.m_stb_i[0] = 1'b0;
    bus.s_ack_i    = 1'b1;
    bus.s_din_i    = 8'hA5;
    ack_q.push_back(ak(2'b01, 8'hA5));
    mid();
    chk("rd_m1_stall", bus.m_stall_o[1], 1);
    tick();
    bus.s_ack_i    = 1'b0;
    bus.s_din_i    = 8'h00;
    bus.m_cyc_i[0] = 1'b0;
    mid();
    chk("rd_ack_once", bus.m_ack_o, 0);
    tick(); mid();
    chk("rd_back_idle", {bus.grant_o, state}, 0);

    // Simultaneous requests, three rounds strictly round-robin
    do_reset();
    gq.push_back(2'b01);
    gq.push_back(2'b10);
    gq.push_back(2'b01);
    tick();
    bus.m_cyc_i = 2'b11;
    mid();
    chk("rr_idle0", bus.grant_o, 0);
    for (int r = 0; r < 3; r++) begin
      tick(); mid();
      g = gq.pop_front();
      chk("rr_grant", bus.grant_o, g);
      chk("rr_scyc", bus.s_cyc_o, 1);
      bus.m_cyc_i = bus.m_cyc_i & ~g;
      tick(); mid();
      chk("rr_turnaround", {bus.grant_o, state}, 0);
      if (r < 2) bus.m_cyc_i = 2'b11;
      else bus.m_cyc_i = '0;
    end

    // M1 pipelined writes: REG then KBD
    tick();
    drv(1, 1, 1, 1, 20'h40000, 8'h3C);
    exp_q.push_back(xf(3'b010, 1'b1, 20'h40000, 8'h3C));
    mid();
    tick(); mid();
    chk("wr_grant", bus.grant_o, 2'b10);
    chk("wr_reg", {bus.ram_sel_o, bus.reg_sel_o, bus.kbd_sel_o, bus.s_we_o}, 4'b0101);
    chk("wr_dout0", bus.s_dout_o, 8'h3C);
    tick();
    drv(1, 1, 1, 1, 20'h60003, 8'hC3);
    bus.s_ack_i = 1'b1;
    exp_q.push_back(xf(3'b001, 1'b1, 20'h60003, 8'hC3));
    ack_q.push_back(ak(2'b10, 8'h00));
    mid();
    chk("wr_kbd", {bus.ram_sel_o, bus.reg_sel_o, bus.kbd_sel_o, bus.s_we_o}, 4'b0011);
    chk("wr_dout1", bus.s_dout_o, 8'hC3);
    tick();
    bus.m_stb_i[1] = 1'b0;
    ack_q.push_back(ak(2'b10, 8'h00));
    mid();
    chk("wr_stb_off", bus.s_stb_o, 0);
    tick();
    bus.s_ack_i    = 1'b0;
    bus.m_cyc_i[1] = 1'b0;
    mid();
    tick(); mid();
    chk("wr_back_idle", state, ST_IDLE);

    // M0 unmapped strobe: local err, slave ack ignored
    tick();
    drv(0, 1, 1, 0, 20'h20000, 8'h00);
    bus.s_stall_i = 1'b1;
    bus.s_ack_i   = 1'b1;
    mid();
    chk("um_idle_ack", bus.m_ack_o, 0);
    tick(); mid();
    chk("um_grant", bus.grant_o, 2'b01);
    chk("um_ctrl", {bus.s_cyc_o, bus.s_stb_o, bus.ram_sel_o, bus.reg_sel_o, bus.kbd_sel_o}, 5'b10000);
    chk("um_stall", bus.m_stall_o, 2'b10);
    chk("um_no_err_yet", bus.m_err_o, 0);
    tick();
    bus.m_stb_i[0] = 1'b0;
    mid();
    chk("um_err", bus.m_err_o, 2'b01);
    chk("um_no_ack", bus.m_ack_o, 0);
    tick(); mid();
    chk("um_err_pulse", bus.m_err_o, 0);
    tick();
    bus.m_cyc_i[0] = 1'b0;
    bus.s_ack_i    = 1'b0;
    bus.s_stall_i  = 1'b0;
    mid();
    tick(); mid();

    // M1 abandons a stalled strobe; a late ack in IDLE is discarded
    tick();
    drv(1, 1, 1, 0, 20'h00100, 8'h00);
    bus.s_stall_i = 1'b1;
    mid();
    tick(); mid();
    chk("ab_grant", bus.grant_o, 2'b10);
    tick();
    bus.m_cyc_i[1] = 1'b0;
    bus.m_stb_i[1] = 1'b0;
    mid();
    chk("ab_scyc_drop", bus.s_cyc_o, 0);
    tick();
    bus.s_ack_i = 1'b1;
    mid();
    chk("ab_late_ack", {bus.grant_o, bus.m_ack_o}, 0);
    tick();
    bus.s_ack_i   = 1'b0;
    bus.s_stall_i = 1'b0;

    // Async reset in the middle of a granted, stalled cycle
    do_reset();
    tick();
    drv(0, 1, 1, 0, 20'h08010, 8'h00);
    bus.s_stall_i = 1'b1;
    mid();
    tick(); mid();
    chk("ar_grant", bus.grant_o, 2'b01);
    #2;
    rst_n       = 1'b0;
    bus.s_ack_i = 1'b1;
    #1;
    chk("ar_grant_clr", bus.grant_o, 0);
    chk("ar_scyc", bus.s_cyc_o, 0);
    chk("ar_stall", bus.m_stall_o, 2'b11);
    chk("ar_ack_err", {bus.m_ack_o, bus.m_err_o}, 0);
    chk("ar_state", state, ST_IDLE);
    tick();
    bus_idle();
    @(negedge clk);
    rst_n = 1'b1;

`ifdef WB_TIMEOUT_EN
    // Watchdog: held stall forces err at count 8, then M1 gets the bus
    do_reset();
    tick();
    drv(0, 1, 1, 0, 20'h08000, 8'h00);
    drv(1, 1, 0, 0, 20'h00000, 8'h00);
    bus.s_stall_i = 1'b1;
    mid();
    tick(); mid();
    chk("to_grant", bus.grant_o, 2'b01);
    chk("to_scyc0", bus.s_cyc_o, 1);
    for (int i = 1; i < 8; i++) begin
      tick(); mid();
      chk("to_wait", {bus.s_cyc_o, bus.m_err_o}, {1'b1, 2'b00});
    end
    tick(); mid();
    chk("to_err", bus.m_err_o, 2'b01);
    chk("to_scyc_forced", bus.s_cyc_o, 0);
    tick();
    bus.m_cyc_i[0] = 1'b0;
    bus.m_stb_i[0] = 1'b0;
    mid();
    chk("to_err_pulse", {bus.s_cyc_o, bus.m_err_o}, 0);
    tick(); mid();
    chk("to_idle", {bus.grant_o, state}, 0);
    tick(); mid();
    chk("to_m1_grant", bus.grant_o, 2'b10);
    tick();
    bus_idle();
    tick();
`endif

    tick();
    chk("exp_q_drained", exp_q.size(), 0);
    chk("ack_q_drained", ack_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
